// File: rtl/q_measure_avg.sv
// Settled Q-sample averager: blanks for a settling window after enable or any
// i_ref_setup change, then publishes back-to-back averages of 2**LOG2_N samples.
module q_measure_avg #(
   parameter int unsigned WIDTH         = 10,
   parameter int unsigned LOG2_N        = 2,
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] i_ref_setup,
   input  logic             adc_valid,
   input  logic [WIDTH-1:0] adc_data,
   output logic [WIDTH-1:0] q_measured,
   output logic             q_valid,
   output logic             busy
);

   localparam int unsigned ACC_W = WIDTH + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;
   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_RELOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_SAMPLE   = CNT_W'((1 << LOG2_N) - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

   state_t             state, state_d;
   logic [SET_W-1:0]   settle_cnt, settle_d;
   logic [ACC_W-1:0]   acc, acc_d, sum;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [WIDTH-1:0]   i_ref_prev, q_d;
   logic               qv_d, ref_changed;

   assign ref_changed = (i_ref_setup != i_ref_prev);
   assign sum         = acc + ACC_W'(adc_data);

   always_comb begin
      state_d  = state;
      settle_d = settle_cnt;
      acc_d    = acc;
      cnt_d    = cnt;
      q_d      = q_measured;
      qv_d     = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_d  = SETTLE;
               settle_d = SETTLE_RELOAD;
            end
            SETTLE: begin
               if (ref_changed) begin
                  settle_d = SETTLE_RELOAD;
               end else if (settle_cnt == '0) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  settle_d = settle_cnt - SET_W'(1);
               end
            end
            ACCUM: begin
               if (ref_changed) begin
                  state_d  = SETTLE;
                  settle_d = SETTLE_RELOAD;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else if (adc_valid) begin
                  // The N-th sample is folded in directly so the result lands on this edge.
                  if (cnt == LAST_SAMPLE) begin
                     q_d   = WIDTH'(sum >> LOG2_N);
                     qv_d  = 1'b1;
                     acc_d = '0;
                     cnt_d = '0;
                  end else begin
                     acc_d = sum;
                     cnt_d = cnt + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         acc        <= '0;
         cnt        <= '0;
         q_measured <= '0;
         q_valid    <= 1'b0;
         busy       <= 1'b0;
         i_ref_prev <= '0;
      end else begin
         state      <= state_d;
         settle_cnt <= settle_d;
         acc        <= acc_d;
         cnt        <= cnt_d;
         q_measured <= q_d;
         q_valid    <= qv_d;
         busy       <= (state_d != IDLE);
         i_ref_prev <= i_ref_setup;
      end
   end

endmodule

// File: tb/tb_q_measure_avg.sv
// Directed bench for q_measure_avg: table of 4-sample averages run back to back,
// plus hand-written sequences for ref changes, valid gaps, disable and reset.
module tb_q_measure_avg;

   localparam int unsigned WIDTH = 10;
   localparam int unsigned SETTLE = 8;

   logic             clk = 1'b0;
   logic             rst, enable, adc_valid;
   logic [WIDTH-1:0] i_ref_setup, adc_data;
   logic [WIDTH-1:0] q_measured;
   logic             q_valid, busy;

   int n_checks = 0;
   int n_fail   = 0;

   q_measure_avg #(.WIDTH(WIDTH), .LOG2_N(2), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst), .enable(enable), .i_ref_setup(i_ref_setup),
      .adc_valid(adc_valid), .adc_data(adc_data),
      .q_measured(q_measured), .q_valid(q_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][WIDTH-1:0] s;
      logic [WIDTH-1:0]      avg;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Ticks n SETTLE-state edges with junk samples offered; none may be absorbed.
   task automatic wait_settle(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         adc_valid = 1'b1;
         adc_data  = 10'd1000;
         tick();
         chk({name, "_settle_qv"}, int'(q_valid), 0);
         chk({name, "_settle_busy"}, int'(busy), 1);
      end
   endtask

   task automatic measure(input string name, input logic [3:0][WIDTH-1:0] s,
                          input logic [WIDTH-1:0] exp);
      for (int k = 0; k < 4; k++) begin
         adc_valid = 1'b1;
         adc_data  = s[k];
         tick();
         if (k < 3) begin
            chk({name, "_qv_low"}, int'(q_valid), 0);
         end else begin
            chk({name, "_qv"}, int'(q_valid), 1);
            chk({name, "_q"}, int'(q_measured), int'(exp));
         end
      end
   endtask

   task automatic feed(input string name, input int n, input logic [WIDTH-1:0] d);
      for (int k = 0; k < n; k++) begin
         adc_valid = 1'b1;
         adc_data  = d;
         tick();
         chk({name, "_feed_qv"}, int'(q_valid), 0);
      end
   endtask

   initial begin
      vecs[0] = '{s: {10'd112, 10'd108, 10'd104, 10'd100}, avg: 10'd106};
      vecs[1] = '{s: {10'd1022, 10'd1023, 10'd1023, 10'd1023}, avg: 10'd1022};
      vecs[2] = '{s: {10'd3, 10'd0, 10'd0, 10'd0}, avg: 10'd0};
      vecs[3] = '{s: {10'd4, 10'd3, 10'd2, 10'd1}, avg: 10'd2};
      vecs[4] = '{s: {10'd7, 10'd7, 10'd7, 10'd7}, avg: 10'd7};
      vecs[5] = '{s: {10'd1, 10'd0, 10'd511, 10'd512}, avg: 10'd256};

      rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; i_ref_setup = 10'd50;
      tick(); tick();
      chk("reset_q", int'(q_measured), 0);
      chk("reset_qv", int'(q_valid), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);

      // Enable edge is cycle 1; first result must appear on cycle 13.
      enable = 1'b1; adc_valid = 1'b1; adc_data = 10'd1000;
      tick();
      chk("enable_busy", int'(busy), 1);
      wait_settle("first", SETTLE);
      for (int i = 0; i < 6; i++) measure($sformatf("vec%0d", i), vecs[i].s, vecs[i].avg);
      adc_valid = 1'b0;
      tick();
      chk("qv_single_cycle", int'(q_valid), 0);
      chk("q_hold", int'(q_measured), 256);

      // Ref change after 2 samples: partial sum dropped, full settle again.
      feed("chg_mid", 2, 10'd200);
      i_ref_setup = 10'd60; adc_valid = 1'b1; adc_data = 10'd200;
      tick();
      chk("chg_mid_qv", int'(q_valid), 0);
      chk("chg_mid_busy", int'(busy), 1);
      wait_settle("chg_mid", SETTLE);
      measure("after_chg", {10'd20, 10'd16, 10'd12, 10'd8}, 10'd14);

      // Ref change coincident with 4th sample: change wins.
      feed("chg_4th", 3, 10'd300);
      i_ref_setup = 10'd70; adc_valid = 1'b1; adc_data = 10'd300;
      tick();
      chk("chg_4th_qv", int'(q_valid), 0);
      chk("chg_4th_q", int'(q_measured), 14);
      chk("chg_4th_busy", int'(busy), 1);
      wait_settle("chg_4th", SETTLE);

      // 50% valid gaps only stall the count.
      for (int k = 0; k < 8; k++) begin
         adc_valid = (k % 2 == 0);
         adc_data  = (k % 2 == 0) ? WIDTH'(40 + 2 * k) : 10'd999;
         tick();
         if (k == 6) begin
            chk("gaps_qv", int'(q_valid), 1);
            chk("gaps_q", int'(q_measured), 46);
         end else begin
            chk("gaps_qv_low", int'(q_valid), 0);
         end
      end

      // Disable mid-ACCUM, then re-enable needs a full settle.
      feed("dis_mid", 2, 10'd500);
      enable = 1'b0; adc_valid = 1'b1; adc_data = 10'd500;
      tick();
      chk("dis_busy", int'(busy), 0);
      chk("dis_qv", int'(q_valid), 0);
      chk("dis_q", int'(q_measured), 46);
      tick();
      chk("dis_idle_busy", int'(busy), 0);
      enable = 1'b1;
      tick();
      chk("reen_busy", int'(busy), 1);
      wait_settle("reen", SETTLE);
      measure("reen", {10'd61, 10'd60, 10'd60, 10'd60}, 10'd60);

      // Enable drop on the 4th sample: no update.
      feed("dis_4th", 3, 10'd400);
      enable = 1'b0; adc_valid = 1'b1; adc_data = 10'd400;
      tick();
      chk("dis_4th_qv", int'(q_valid), 0);
      chk("dis_4th_q", int'(q_measured), 60);
      chk("dis_4th_busy", int'(busy), 0);

      // Reset mid-ACCUM clears q_measured too.
      enable = 1'b1;
      tick();
      wait_settle("pre_rst", SETTLE);
      feed("pre_rst", 2, 10'd80);
      rst = 1'b1;
      tick();
      chk("rst_mid_q", int'(q_measured), 0);
      chk("rst_mid_qv", int'(q_valid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      rst = 1'b0; enable = 1'b0;
      tick();

      // Ref-driven lookup: each step gives one settle window, then its own value.
      enable = 1'b1;
      tick();
      wait_settle("loop_start", SETTLE);
      for (int r = 0; r < 3; r++) begin
         logic [WIDTH-1:0] q_of_ref;
         i_ref_setup = WIDTH'(100 + 10 * r);
         q_of_ref    = WIDTH'(2 * (100 + 10 * r) + 1);
         adc_valid = 1'b1; adc_data = q_of_ref;
         tick();
         chk($sformatf("loop%0d_step_qv", r), int'(q_valid), 0);
         wait_settle($sformatf("loop%0d", r), SETTLE);
         measure($sformatf("loop%0d", r), {q_of_ref, q_of_ref, q_of_ref, q_of_ref}, q_of_ref);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
